// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS stage controller.
//   state_e      : controller state encoding (3 bits)
//   STG_*        : bit index of each stage in stage_en / stage_done
//   stage_onehot : state -> one-hot stage enable (all zero outside stage states)
package mips_ctrl_pkg;

  localparam int unsigned NUM_STAGES       = 5;
  localparam int unsigned STG_IF           = 0;
  localparam int unsigned STG_ID           = 1;
  localparam int unsigned STG_EX           = 2;
  localparam int unsigned STG_MEM          = 3;
  localparam int unsigned STG_WB           = 4;
  localparam int unsigned DEFAULT_PC_WIDTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6,
    ST_ERROR     = 3'd7
  } state_e;

  // One-hot enable for the stage owned by a state.
  function automatic logic [NUM_STAGES-1:0] stage_onehot(input state_e s);
    logic [NUM_STAGES-1:0] oh;
    oh = '0;
    case (s)
      ST_FETCH:     oh[STG_IF]  = 1'b1;
      ST_DECODE:    oh[STG_ID]  = 1'b1;
      ST_EXECUTE:   oh[STG_EX]  = 1'b1;
      ST_MEMORY:    oh[STG_MEM] = 1'b1;
      ST_WRITEBACK: oh[STG_WB]  = 1'b1;
      default:      oh          = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/stage_timer.sv
// Stage residency timer: clear / hold / increment counter.
//   clock : rising-edge clock
//   start : asynchronous active-high reset
//   clear : restart counting (state change or non-stage state)
//   hold  : freeze count (stall)
//   tc_c  : current cycle is the MAX_WAIT-th unstalled cycle in this state
module stage_timer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clock,
  input  logic start,
  input  logic clear,
  input  logic hold,
  output logic tc_c
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Saturates at LAST; the FSM leaves the state on that edge anyway.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (!hold && (count_q != LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_c = (count_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle controller for the five-stage MIPS datapath.
//   clock, start        : clock / asynchronous active-high reset
//   run                 : leave IDLE and begin fetching
//   stall               : freeze state, ignore done, pause timer
//   stage_done[4:0]     : per-stage done (bit0 = fetch .. bit4 = writeback)
//   skip_mem, skip_wb,
//   end_program         : decode results, valid with stage_done[1]
//   branch_taken,
//   branch_target       : ALU results, valid with stage_done[2]
//   stage_en[4:0]       : one-hot active-stage enable
//   pc, instr_count     : fetch index / retired-instruction count
//   busy, halted,
//   timeout_err         : status decoded from state
module stage_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = DEFAULT_PC_WIDTH,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic                  clock,
  input  logic                  start,
  input  logic                  run,
  input  logic                  stall,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic                  skip_mem,
  input  logic                  skip_wb,
  input  logic                  end_program,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [CNT_WIDTH-1:0]  instr_count,
  output logic                  busy,
  output logic                  halted,
  output logic                  timeout_err
);

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  skip_mem_q, skip_mem_d;
  logic                  skip_wb_q, skip_wb_d;
  logic                  br_taken_q, br_taken_d;
  logic [PC_WIDTH-1:0]   br_target_q, br_target_d;
  logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  err_q, err_d;

  logic active_done_c;
  logic advance_c;
  logic expire_c;
  logic retire_c;
  logic timer_clear_c;
  logic tc_c;

  stage_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .clock (clock),
    .start (start),
    .clear (timer_clear_c),
    .hold  (stall),
    .tc_c  (tc_c)
  );

  // Next-state, PC/count update and registered-output decode.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    skip_mem_d  = skip_mem_q;
    skip_wb_d   = skip_wb_q;
    br_taken_d  = br_taken_q;
    br_target_d = br_target_q;
    retire_c    = 1'b0;

    // Only the active stage's done bit matters; stall beats done, done beats timeout.
    active_done_c = |(stage_done & stage_onehot(state_q));
    advance_c     = active_done_c && !stall;
    expire_c      = !stall && !active_done_c && tc_c;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (advance_c)     state_d = ST_DECODE;
        else if (expire_c) state_d = ST_ERROR;
      end
      ST_DECODE: begin
        if (advance_c) begin
          skip_mem_d = skip_mem;
          skip_wb_d  = skip_wb;
          state_d    = end_program ? ST_HALT : ST_EXECUTE;
        end else if (expire_c) begin
          state_d = ST_ERROR;
        end
      end
      ST_EXECUTE: begin
        if (advance_c) begin
          br_taken_d  = branch_taken;
          br_target_d = branch_target;
          if (skip_mem_q && skip_wb_q) retire_c = 1'b1;
          else if (skip_mem_q)         state_d  = ST_WRITEBACK;
          else                         state_d  = ST_MEMORY;
        end else if (expire_c) begin
          state_d = ST_ERROR;
        end
      end
      ST_MEMORY: begin
        if (advance_c) begin
          if (skip_wb_q) retire_c = 1'b1;
          else           state_d  = ST_WRITEBACK;
        end else if (expire_c) begin
          state_d = ST_ERROR;
        end
      end
      ST_WRITEBACK: begin
        if (advance_c)     retire_c = 1'b1;
        else if (expire_c) state_d  = ST_ERROR;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // br_taken_d carries the live ALU result when retiring straight out of EXECUTE.
    if (retire_c) begin
      state_d = ST_FETCH;
      pc_d    = br_taken_d ? br_target_d : pc_q + PC_WIDTH'(1);
      cnt_d   = cnt_q + CNT_WIDTH'(1);
    end

    timer_clear_c = (state_d != state_q) || (stage_onehot(state_q) == '0);

    stage_en_d = stage_onehot(state_d);
    busy_d     = |stage_en_d;
    halted_d   = (state_d == ST_HALT);
    err_d      = (state_d == ST_ERROR);
  end

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      skip_mem_q  <= 1'b0;
      skip_wb_q   <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      stage_en_q  <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      skip_mem_q  <= skip_mem_d;
      skip_wb_q   <= skip_wb_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      stage_en_q  <= stage_en_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
    end
  end

  assign stage_en    = stage_en_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: vector table for the instruction walk,
// hand sequences for stall/timeout and asynchronous reset.
module tb_stage_sequencer;

  logic        clock = 1'b0;
  logic        start;
  logic        run;
  logic        stall;
  logic [4:0]  stage_done;
  logic        skip_mem;
  logic        skip_wb;
  logic        end_program;
  logic        branch_taken;
  logic [3:0]  branch_target;
  logic [4:0]  stage_en;
  logic [3:0]  pc;
  logic [15:0] instr_count;
  logic        busy;
  logic        halted;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  stage_sequencer #(
    .PC_WIDTH  (4),
    .CNT_WIDTH (16),
    .MAX_WAIT  (15)
  ) dut (
    .clock         (clock),
    .start         (start),
    .run           (run),
    .stall         (stall),
    .stage_done    (stage_done),
    .skip_mem      (skip_mem),
    .skip_wb       (skip_wb),
    .end_program   (end_program),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stage_en      (stage_en),
    .pc            (pc),
    .instr_count   (instr_count),
    .busy          (busy),
    .halted        (halted),
    .timeout_err   (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic [4:0]  done;
    logic        sm, sw, ep, bt;
    logic [3:0]  tgt;
    logic [4:0]  en;
    logic [3:0]  pc;
    logic [15:0] cnt;
    logic        busy, halted, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [4:0] d,
                              input logic sm, input logic sw, input logic ep,
                              input logic bt, input logic [3:0] tgt,
                              input logic [4:0] en, input logic [3:0] p,
                              input logic [15:0] c, input logic b,
                              input logic h, input logic e);
    vec_t v;
    v.stall = st; v.done = d; v.sm = sm; v.sw = sw; v.ep = ep; v.bt = bt; v.tgt = tgt;
    v.en = en; v.pc = p; v.cnt = c; v.busy = b; v.halted = h; v.err = e;
    return v;
  endfunction

  function automatic logic [27:0] pack(input logic [4:0] en, input logic [3:0] p,
                                       input logic [15:0] c, input logic b,
                                       input logic h, input logic e);
    return {en, p, c, b, h, e};
  endfunction

  function automatic logic [27:0] outs();
    return {stage_en, pc, instr_count, busy, halted, timeout_err};
  endfunction

  task automatic chk(input string name, input logic [27:0] got, input logic [27:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic st, input logic [4:0] d, input logic sm,
                        input logic sw, input logic ep, input logic bt,
                        input logic [3:0] tgt);
    stall = st; stage_done = d; skip_mem = sm; skip_wb = sw;
    end_program = ep; branch_taken = bt; branch_target = tgt;
  endtask

  task automatic do_reset();
    start = 1'b1;
    run   = 1'b0;
    set_in(1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick();
    tick();
    start = 1'b0;
  endtask

  // IDLE -> FETCH -> DECODE -> EXECUTE -> MEMORY, no skips.
  task automatic run_to_mem();
    run = 1'b1;
    tick();
    set_in(1'b0, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0); tick();
    set_in(1'b0, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0); tick();
    set_in(1'b0, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0); tick();
    set_in(1'b0, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    // Instruction 1: full five-stage walk (with a foreign done pattern ignored).
    vecs.push_back(mk(0, 5'b00000, 0, 0, 0, 0, 4'h0, 5'b00001, 4'h0, 16'd0, 1, 0, 0));
    vecs.push_back(mk(0, 5'b11110, 0, 0, 0, 0, 4'h0, 5'b00001, 4'h0, 16'd0, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 4'h0, 5'b00010, 4'h0, 16'd0, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00010, 0, 0, 0, 0, 4'h0, 5'b00100, 4'h0, 16'd0, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00100, 0, 0, 0, 0, 4'h0, 5'b01000, 4'h0, 16'd0, 1, 0, 0));
    vecs.push_back(mk(0, 5'b01000, 0, 0, 0, 0, 4'h0, 5'b10000, 4'h0, 16'd0, 1, 0, 0));
    vecs.push_back(mk(0, 5'b10000, 0, 0, 0, 0, 4'h0, 5'b00001, 4'h1, 16'd1, 1, 0, 0));
    // Instruction 2: skip memory and writeback, retires from EXECUTE.
    vecs.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 4'h0, 5'b00010, 4'h1, 16'd1, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00010, 1, 1, 0, 0, 4'h0, 5'b00100, 4'h1, 16'd1, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00100, 0, 0, 0, 0, 4'h0, 5'b00001, 4'h2, 16'd2, 1, 0, 0));
    // Instruction 3: taken branch to 0xA through all stages.
    vecs.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 4'h0, 5'b00010, 4'h2, 16'd2, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00010, 0, 0, 0, 0, 4'h0, 5'b00100, 4'h2, 16'd2, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00100, 0, 0, 0, 1, 4'hA, 5'b01000, 4'h2, 16'd2, 1, 0, 0));
    vecs.push_back(mk(0, 5'b01000, 0, 0, 0, 0, 4'h0, 5'b10000, 4'h2, 16'd2, 1, 0, 0));
    vecs.push_back(mk(0, 5'b10000, 0, 0, 0, 0, 4'h0, 5'b00001, 4'hA, 16'd3, 1, 0, 0));
    // Instruction 4: skip memory only, branch to 0xF.
    vecs.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 4'h0, 5'b00010, 4'hA, 16'd3, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00010, 1, 0, 0, 0, 4'h0, 5'b00100, 4'hA, 16'd3, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00100, 0, 0, 0, 1, 4'hF, 5'b10000, 4'hA, 16'd3, 1, 0, 0));
    vecs.push_back(mk(0, 5'b10000, 0, 0, 0, 0, 4'h0, 5'b00001, 4'hF, 16'd4, 1, 0, 0));
    // Instruction 5: stall beats done, then skip writeback; pc wraps F -> 0.
    vecs.push_back(mk(1, 5'b00001, 0, 0, 0, 0, 4'h0, 5'b00001, 4'hF, 16'd4, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 4'h0, 5'b00010, 4'hF, 16'd4, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00010, 0, 1, 0, 0, 4'h0, 5'b00100, 4'hF, 16'd4, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00100, 0, 0, 0, 0, 4'h0, 5'b01000, 4'hF, 16'd4, 1, 0, 0));
    vecs.push_back(mk(0, 5'b01000, 0, 0, 0, 0, 4'h0, 5'b00001, 4'h0, 16'd5, 1, 0, 0));
    // Instructions 6..8: three-cycle instructions, pc 0 -> 3.
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 4'h0, 5'b00010, 4'(k), 16'(5 + k), 1, 0, 0));
      vecs.push_back(mk(0, 5'b00010, 1, 1, 0, 0, 4'h0, 5'b00100, 4'(k), 16'(5 + k), 1, 0, 0));
      vecs.push_back(mk(0, 5'b00100, 0, 0, 0, 0, 4'h0, 5'b00001, 4'(k + 1), 16'(6 + k), 1, 0, 0));
    end
    // end_program at pc=3: HALT, then further dones ignored.
    vecs.push_back(mk(0, 5'b00001, 0, 0, 0, 0, 4'h0, 5'b00010, 4'h3, 16'd8, 1, 0, 0));
    vecs.push_back(mk(0, 5'b00010, 0, 0, 1, 0, 4'h0, 5'b00000, 4'h3, 16'd8, 0, 1, 0));
    vecs.push_back(mk(0, 5'b11111, 0, 0, 0, 0, 4'h0, 5'b00000, 4'h3, 16'd8, 0, 1, 0));
    vecs.push_back(mk(0, 5'b00001, 0, 0, 1, 1, 4'hF, 5'b00000, 4'h3, 16'd8, 0, 1, 0));

    // Reset state.
    do_reset();
    chk("reset", outs(), pack(5'b0, 4'h0, 16'd0, 0, 0, 0));
    tick();
    chk("idle_no_run", outs(), pack(5'b0, 4'h0, 16'd0, 0, 0, 0));

    run = 1'b1;
    foreach (vecs[i]) begin
      set_in(vecs[i].stall, vecs[i].done, vecs[i].sm, vecs[i].sw, vecs[i].ep,
             vecs[i].bt, vecs[i].tgt);
      tick();
      chk($sformatf("vec%0d", i), outs(),
          pack(vecs[i].en, vecs[i].pc, vecs[i].cnt, vecs[i].busy,
               vecs[i].halted, vecs[i].err));
    end

    // Stall 20 cycles in MEMORY, then withhold done: ERROR on the 15th unstalled edge.
    do_reset();
    run_to_mem();
    chk("at_mem", outs(), pack(5'b01000, 4'h0, 16'd0, 1, 0, 0));
    stall = 1'b1;
    stage_done = 5'b01000;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("stall%0d", k), outs(), pack(5'b01000, 4'h0, 16'd0, 1, 0, 0));
    end
    stall = 1'b0;
    stage_done = 5'b10111;
    for (int k = 1; k < 15; k++) begin
      tick();
      chk($sformatf("wait%0d", k), outs(), pack(5'b01000, 4'h0, 16'd0, 1, 0, 0));
    end
    tick();
    chk("timeout", outs(), pack(5'b0, 4'h0, 16'd0, 0, 0, 1));
    stage_done = 5'b11111;
    run = 1'b1;
    tick();
    tick();
    chk("error_sticky", outs(), pack(5'b0, 4'h0, 16'd0, 0, 0, 1));

    // Done arriving on the would-be timeout edge wins.
    do_reset();
    run_to_mem();
    for (int k = 1; k < 15; k++) tick();
    chk("pre_edge", outs(), pack(5'b01000, 4'h0, 16'd0, 1, 0, 0));
    stage_done = 5'b01000;
    tick();
    chk("done_vs_timeout", outs(), pack(5'b10000, 4'h0, 16'd0, 1, 0, 0));

    // Asynchronous reset in EXECUTE aborts the instruction.
    do_reset();
    run = 1'b1;
    tick();
    stage_done = 5'b00001; tick();
    stage_done = 5'b00010; tick();
    stage_done = 5'b00000;
    chk("at_exec", outs(), pack(5'b00100, 4'h0, 16'd0, 1, 0, 0));
    #2;
    stage_done = 5'b00100;
    start = 1'b1;
    #1;
    chk("async_reset", outs(), pack(5'b0, 4'h0, 16'd0, 0, 0, 0));
    tick();
    start = 1'b0;
    stage_done = 5'b00000;
    tick();
    chk("restart", outs(), pack(5'b00001, 4'h0, 16'd0, 1, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
Multicycle controller for the five-stage MIPS datapath: fetch, decode, ALU, memory and write-back.
- Replaces free-running stage handshake wiring with one FSM that issues one-hot stage enables, waits for each stage's done, and skips memory/write-back when unneeded.
- Owns the PC, retires instructions, detects program end, and traps hung stages.
- Sits at top level beside the stage modules; drives their stage-enable inputs and the fetch PC.

Parameters:
PC_WIDTH, 4, width of program counter (instruction index, wraps modulo 2^PC_WIDTH)
CNT_WIDTH, 16, width of retired-instruction counter
MAX_WAIT, 15, max cycles a stage may stay active without done before ERROR (1..2^8-1)

Ports:
clock  in  1  system clock, rising edge
start  in  1  asynchronous active-high reset
run  in  1  level; leave IDLE and begin fetching
stall  in  1  freeze current state; done ignored, timer paused
stage_done  in  5  per-stage done pulses, bit0=fetch .. bit4=writeback
skip_mem  in  1  from decode, valid with stage_done[1]: no memRead/memWrite
skip_wb  in  1  from decode, valid with stage_done[1]: no regWrite
end_program  in  1  from decode, valid with stage_done[1]
branch_taken  in  1  from ALU, valid with stage_done[2]
branch_target  in  PC_WIDTH  from ALU, valid with stage_done[2]
stage_en  out  5  one-hot active-stage enable, same bit order as stage_done
pc  out  PC_WIDTH  current instruction index to fetch
instr_count  out  CNT_WIDTH  retired instructions, wraps
busy  out  1  high in any stage state
halted  out  1  high in HALT
timeout_err  out  1  high in ERROR (sticky until start)

Behaviour:
- Reset (start=1, async): state=IDLE; stage_en=0, pc=0, instr_count=0, busy=0, halted=0, timeout_err=0; latched branch/skip flags cleared. Reset mid-instruction aborts it; nothing retires.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, ERROR.
- Outputs are registered and decoded from state: stage_en has exactly one bit set in FETCH..WRITEBACK, otherwise 0.
- IDLE -> FETCH on the first rising edge with run=1. run is not sampled again afterward.
- Each stage state advances on a rising edge where its own stage_done bit=1 and stall=0. Minimum residency is 1 cycle.
- stage_done bits for non-active stages are ignored.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: latch skip_mem/skip_wb. If end_program=1, go to HALT; nothing retires and pc holds. Otherwise go to EXECUTE.
  - EXECUTE: latch branch_taken/branch_target. Go to MEMORY, or WRITEBACK if skip_mem, or retire if skip_mem&&skip_wb.
  - MEMORY -> WRITEBACK, or retire if skip_wb.
  - WRITEBACK -> retire.
- Retire (same edge as the final done):
  - pc <= branch_target if latched taken, else pc+1 (wrap 2^PC_WIDTH-1 -> 0).
  - instr_count += 1 (wraps).
  - state <= FETCH.
- Latency: full instruction = 5 cycles minimum; skip_mem alone = 4; skip_mem+skip_wb = 3.
- Timer: counts cycles spent in the current stage state. Clears on state change, holds while stall=1. If it reaches MAX_WAIT with done still absent and stall=0, go to ERROR on that edge.
- Simultaneous events: stall beats done; done beats timeout on the same edge.
- HALT and ERROR are absorbing until start: stage_en=0, pc frozen, instr_count frozen.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state enum encoding (3 bits)
  - stage index constants STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4
  - default PC_WIDTH
- One sub-module, stage_timer: clear/hold/increment counter with terminal-count flag at MAX_WAIT. Everything else stays in the FSM.

Test Plan:
- Reset, run=1; return each stage_done one cycle after its enable, skip flags 0 -> stage_en walks 00001..10000, pc 0->1, instr_count=1 after 5 cycles.
- DECODE with skip_mem=1, skip_wb=1 -> EXECUTE done retires directly; instruction takes 3 cycles; stage_en never 01000/10000.
- EXECUTE done with branch_taken=1, target=4'hA -> after WRITEBACK, pc=4'hA. Separately, non-branch at pc=4'hF -> pc wraps to 0.
- end_program=1 with stage_done[1] at pc=3 -> halted=1, stage_en=0, pc stays 3, instr_count unchanged. Further stage_done pulses are ignored.
- Hold stall=1 for 20 cycles in MEMORY, then withhold done for 15 cycles -> no error during stall; timeout_err=1 exactly 15 unstalled cycles later. Done and timeout on the same edge -> advances, no error.
- Assert start in EXECUTE -> all outputs zero immediately (async), IDLE; run restarts at pc=0.
